pixel_scanout: RTL and testbench
================================

PIXEL_SCANOUT -- requirements
Module: pixel_scanout

Interface
REQ-001 Parameter FB_WIDTH, default 320, pixels per framebuffer row.
REQ-002 Parameter ADDR_W, default 18, SRAM word-address width; SHALL satisfy 2^ADDR_W >= FB_WIDTH*511.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to scan one frame.
REQ-006 height  input  9  active rows; sampled on accepted start.
REQ-007 sram_rd_en  output  1  SRAM read strobe.
REQ-008 sram_addr  output  ADDR_W  SRAM read word address.
REQ-009 sram_rdata  input  Color  read data, valid exactly 1 cycle after sram_rd_en.
REQ-010 pix_valid  output  1  pixel available downstream.
REQ-011 pix_ready  input  1  downstream accepts pixel.
REQ-012 pix_color  output  Color  pixel value.
REQ-013 pix_sol  output  1  marks first pixel of a row (col 0).
REQ-014 pix_eof  output  1  marks last pixel of the frame.
REQ-015 busy  output  1  high from accepted start until frame_done.
REQ-016 frame_done  output  1  one-cycle pulse when scan completes.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN; IDLE->SCAN on start with height!=0; SCAN->DRAIN after last read issued; DRAIN->IDLE when last pixel handshaken.
REQ-018 start with height==0 in IDLE: no reads, frame_done pulses next cycle, busy stays low.
REQ-019 start while busy SHALL be ignored; height latch unchanged.
REQ-020 Read order row-major: row 0..height-1, col 0..FB_WIDTH-1; sram_addr = row*FB_WIDTH + col, computed by incremental counters (no multiplier).
REQ-021 Column counter wraps FB_WIDTH-1 -> 0 with row increment; address increments by 1 continuously.
REQ-022 Internal 2-entry pixel buffer; read issued only when buffered + in-flight count < 2, so no read data is ever dropped.
REQ-023 Pixel transfer occurs when pix_valid && pix_ready; pix_color/pix_sol/pix_eof SHALL hold stable while pix_valid && !pix_ready.
REQ-024 sol/eof flags travel with each buffered pixel, derived from the read's row/col at issue time.
REQ-025 Sustained throughput with pix_ready held high: one pixel per cycle after first-pixel latency of 2 cycles from start (read at cycle 1, pix_valid at cycle 2).
REQ-026 Simultaneous buffer write (read return) and transfer in the same cycle SHALL keep count unchanged and preserve order.
REQ-027 frame_done pulses in the cycle after the eof pixel transfer; busy falls in that same cycle.
REQ-028 sram_rd_en SHALL never assert in IDLE or DRAIN.

Reset
REQ-029 n_rst low: state IDLE, counters 0, buffer empty, sram_rd_en 0, sram_addr 0, pix_valid 0, pix_color 0, pix_sol 0, pix_eof 0, busy 0, frame_done 0.
REQ-030 Reset mid-frame SHALL abort immediately; in-flight read data returning after reset release is discarded.

Structure
REQ-031 Color type and FB_WIDTH default constant SHALL live in defines_package; state enum local.
REQ-032 The 2-entry buffer SHALL be a sub-module named pixel_skid_fifo (depth 2, data = Color + 2 flag bits).

Verification
REQ-033 FB_WIDTH=4, height=2, pix_ready=1 -> addrs 0..7 on consecutive cycles, 8 pixels, sol on pixels 0 and 4, eof on pixel 7, frame_done one cycle later.
REQ-034 Same frame, pix_ready toggled 1010... -> identical pixel sequence, no duplicates/drops, outputs stable while stalled.
REQ-035 pix_ready=0 for 10 cycles after start -> at most 2 reads issued, pix_valid held, pixel 0 value unchanged.
REQ-036 height=0 start -> no sram_rd_en, frame_done pulse next cycle; second start during active frame -> ignored, frame length unchanged.
REQ-037 n_rst asserted at pixel 3 of 8 -> all outputs at reset values immediately; new start scans from addr 0.

Source files
------------

// File: rtl/defines_package.sv
// -----------------------------------------------------------------------------
// defines_package
// Shared types and constants for the pixel scan-out slice.
//   Color            : one framebuffer pixel as stored in SRAM (RGB565 word)
//   FB_WIDTH_DEFAULT : default framebuffer row length in pixels
//   pix_word_t       : one buffered pixel with its row/frame markers
// -----------------------------------------------------------------------------
package defines_package;

  typedef logic [15:0] Color;

  localparam int FB_WIDTH_DEFAULT = 320;

  typedef struct packed {
    logic sol;    // first pixel of a row
    logic eof;    // last pixel of the frame
    Color color;
  } pix_word_t;

endpackage

// File: rtl/pixel_scanout_if.sv
// -----------------------------------------------------------------------------
// pixel_scanout_if
// Bundles the two buses of the scan-out engine: the SRAM read port and the
// downstream pixel stream.
//   sram_rd_en / sram_addr : read strobe and word address (engine -> SRAM)
//   sram_rdata             : read data, valid one cycle after sram_rd_en
//   pix_valid / pix_ready  : pixel stream handshake
//   pix_color/sol/eof      : pixel payload and markers
// Modports: master = scan-out engine, slave = SRAM model + pixel sink.
// -----------------------------------------------------------------------------
interface pixel_scanout_if #(
  parameter int ADDR_W = 18
) ();
  import defines_package::*;

  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  Color              sram_rdata;
  logic              pix_valid;
  logic              pix_ready;
  Color              pix_color;
  logic              pix_sol;
  logic              pix_eof;

  modport master (
    output sram_rd_en, sram_addr,
    input  sram_rdata,
    output pix_valid, pix_color, pix_sol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  sram_rd_en, sram_addr,
    output sram_rdata,
    input  pix_valid, pix_color, pix_sol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/pixel_skid_fifo.sv
// -----------------------------------------------------------------------------
// pixel_skid_fifo
// Two-entry pixel buffer with a bypass path: when empty, incoming read data is
// presented downstream in the same cycle it arrives, and is only stored if the
// sink does not take it. Order is preserved; the producer guarantees it never
// pushes into a full buffer.
//   clk, n_rst : clock, asynchronous active-low reset
//   in_valid   : in_data carries a returning SRAM word this cycle
//   in_data    : pixel word (color + sol/eof markers)
//   out_valid  : a pixel is presented downstream
//   out_ready  : downstream accepts the presented pixel
//   out_data   : presented pixel (zero when nothing is presented)
//   count      : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module pixel_skid_fifo
  import defines_package::*;
(
  input  logic      clk,
  input  logic      n_rst,
  input  logic      in_valid,
  input  pix_word_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output pix_word_t out_data,
  output logic [1:0] count
);

  pix_word_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push;
  logic      pop;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned; a missed branch would infer a latch.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (count != 2'd0) begin
      out_valid = 1'b1;
      out_data  = mem[rd_ptr];
      pop       = out_ready;
      push      = in_valid;
    end else if (in_valid) begin
      // Bypass: the arriving word goes straight out, stored only if stalled.
      out_valid = 1'b1;
      out_data  = in_data;
      push      = !out_ready;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers mark
  // which entries are live, and out_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/pixel_scanout.sv
// -----------------------------------------------------------------------------
// pixel_scanout
// Reads one frame row-major out of SRAM and streams it as pixels with
// valid/ready flow control. Reads are credit-limited so the 2-entry buffer can
// always absorb every returning word; with the sink always ready the engine
// sustains one pixel per clock.
//   clk, n_rst  : clock, asynchronous active-low reset
//   start       : one-cycle frame request (ignored while busy)
//   height      : active rows, sampled when start is accepted
//   bus         : pixel_scanout_if.master (SRAM read port + pixel stream)
//   busy        : frame in progress
//   frame_done  : one-cycle pulse when the frame has fully left the engine
// -----------------------------------------------------------------------------
module pixel_scanout
  import defines_package::*;
#(
  parameter int FB_WIDTH = FB_WIDTH_DEFAULT,
  parameter int ADDR_W   = 18
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [8:0]         height,
  pixel_scanout_if.master    bus,
  output logic               busy,
  output logic               frame_done
);

  localparam int COL_W = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state;
  logic [8:0]        height_q;

  // Coordinates of the next read to issue; the address advances by one per
  // read so no row*width product is ever formed.
  logic [ADDR_W-1:0] nxt_addr;
  logic [COL_W-1:0]  nxt_col;
  logic [8:0]        nxt_row;

  // Read currently on the SRAM port, and the word returning this cycle.
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_sol_q;
  logic              rd_eof_q;
  logic              dv_q;
  logic              dv_sol_q;
  logic              dv_eof_q;

  pix_word_t         fifo_in;
  pix_word_t         fifo_out;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic              pix_xfer;

  logic [ADDR_W-1:0] cur_addr;
  logic [COL_W-1:0]  cur_col;
  logic [8:0]        cur_row;
  logic [8:0]        cur_h;
  logic              is_last_col;
  logic              is_last;
  logic [2:0]        items_after;
  logic              credit_ok;
  logic              issue;

  assign fifo_in = '{sol: dv_sol_q, eof: dv_eof_q, color: bus.sram_rdata};

  pixel_skid_fifo u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (dv_q),
    .in_data   (fifo_in),
    .out_valid (fifo_valid),
    .out_ready (bus.pix_ready),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign pix_xfer       = fifo_valid && bus.pix_ready;
  assign bus.pix_valid  = fifo_valid;
  assign bus.pix_color  = fifo_out.color;
  assign bus.pix_sol    = fifo_out.sol;
  assign bus.pix_eof    = fifo_out.eof;
  assign bus.sram_rd_en = rd_en_q;
  assign bus.sram_addr  = addr_q;

  always_comb begin
    // The first read of a frame is issued straight from IDLE (from row/col 0
    // and the live height) to reach the two-cycle first-pixel latency.
    cur_addr    = (state == IDLE) ? '0 : nxt_addr;
    cur_col     = (state == IDLE) ? '0 : nxt_col;
    cur_row     = (state == IDLE) ? '0 : nxt_row;
    cur_h       = (state == IDLE) ? height : height_q;
    is_last_col = (cur_col == COL_W'(FB_WIDTH - 1));
    is_last     = is_last_col && (cur_row == cur_h - 9'd1);

    // Words that will sit in the buffer after this edge, plus the read now on
    // the port (returns next cycle); a new read needs one more free slot.
    items_after = {1'b0, fifo_count} + {2'b00, dv_q} - {2'b00, pix_xfer};
    credit_ok   = (items_after + {2'b00, rd_en_q}) < 3'd2;

    issue = 1'b0;
    case (state)
      IDLE:    issue = start && (height != 9'd0);
      SCAN:    issue = credit_ok;
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      height_q   <= '0;
      nxt_addr   <= '0;
      nxt_col    <= '0;
      nxt_row    <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      rd_sol_q   <= 1'b0;
      rd_eof_q   <= 1'b0;
      dv_q       <= 1'b0;
      dv_sol_q   <= 1'b0;
      dv_eof_q   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_en_q    <= issue;
      dv_q       <= rd_en_q;
      dv_sol_q   <= rd_sol_q;
      dv_eof_q   <= rd_eof_q;

      if (issue) begin
        addr_q   <= cur_addr;
        rd_sol_q <= (cur_col == '0);
        rd_eof_q <= is_last;
        nxt_addr <= cur_addr + ADDR_W'(1);
        nxt_col  <= is_last_col ? '0 : cur_col + COL_W'(1);
        nxt_row  <= is_last_col ? cur_row + 9'd1 : cur_row;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (height == 9'd0) begin
              frame_done <= 1'b1;
            end else begin
              height_q <= height;
              busy     <= 1'b1;
              state    <= is_last ? DRAIN : SCAN;
            end
          end
        end
        SCAN: begin
          if (issue && is_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pix_xfer && fifo_out.eof) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scanout.sv
// -----------------------------------------------------------------------------
// tb_pixel_scanout
// Drives pixel_scanout with FB_WIDTH=4 against a one-cycle-latency SRAM model.
// Expected read addresses and pixels are queued when a frame is requested and
// popped as the DUT issues reads / hands off pixels. Outputs are sampled just
// after the falling edge; cycle n counts falling edges after the start edge.
// -----------------------------------------------------------------------------
module tb_pixel_scanout;
  import defines_package::*;

  localparam int FBW = 4;
  localparam int AW  = 18;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] height = '0;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [17:0]   exp_pix_q  [$];

  pixel_scanout_if #(.ADDR_W(AW)) bus ();

  pixel_scanout #(.FB_WIDTH(FBW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .height     (height),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic Color color_of(input logic [AW-1:0] a);
    return 16'(a) * 16'd97 + 16'h1357;
  endfunction

  // SRAM: data for the strobed address appears the following cycle; any other
  // cycle returns a junk pattern so stray captures show up as wrong pixels.
  always @(posedge clk) begin
    bus.sram_rdata <= bus.sram_rd_en ? color_of(bus.sram_addr) : 16'hDEAD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // mode 0: ready always high; 1: ready alternates (high on even cycles);
  // 2: ready low for stall_n cycles then high. inject_cyc > 0 raises a second
  // start (height 3) during the frame.
  task automatic scan_frame(input string name, input int h, input int mode,
                            input int stall_n, input int inject_cyc);
    int npix, nreads, stall_reads, first_rd, first_val, last_rd, eof_cyc, done_cyc;
    logic        prev_stall;
    logic [17:0] prev_word;
    logic [17:0] got;
    logic [17:0] ep;
    logic [AW-1:0] ea;
    logic [AW-1:0] a;

    a = '0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < FBW; c++) begin
        exp_addr_q.push_back(a);
        exp_pix_q.push_back({c == 0, (r == h - 1) && (c == FBW - 1), color_of(a)});
        a = a + 1'b1;
      end
    end

    npix = 0; nreads = 0; stall_reads = 0;
    first_rd = -1; first_val = -1; last_rd = -1; eof_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_word = '0;

    bus.pix_ready = (mode == 0);
    height = 9'(h);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      case (mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = (cyc % 2 == 0);
        default: bus.pix_ready = (cyc > stall_n);
      endcase
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) height = 9'd3;
      #1;
      got = {bus.pix_sol, bus.pix_eof, bus.pix_color};
      if (frame_done) begin
        done_cyc = cyc;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_during: cyc %0d got %b want 1", name, cyc, busy);
        end
        if (bus.sram_rd_en) begin
          nreads++;
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          if (cyc <= stall_n) stall_reads++;
          total++;
          if (exp_addr_q.size() == 0) begin
            bad++;
            $display("FAIL %s extra_read: cyc %0d addr %0d, none expected", name, cyc, bus.sram_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (bus.sram_addr !== ea) begin
              bad++;
              $display("FAIL %s read_addr: cyc %0d got %0d want %0d", name, cyc, bus.sram_addr, ea);
            end
          end
        end
        if (bus.pix_valid && first_val < 0) first_val = cyc;
        if (prev_stall) begin
          total++;
          if ({bus.pix_valid, got} !== {1'b1, prev_word}) begin
            bad++;
            $display("FAIL %s stall_hold: cyc %0d got %b_%h want %b_%h", name, cyc,
                     bus.pix_valid, got, 1'b1, prev_word);
          end
        end
        if (bus.pix_valid && bus.pix_ready) begin
          npix++;
          total++;
          if (exp_pix_q.size() == 0) begin
            bad++;
            $display("FAIL %s extra_pixel: cyc %0d got %h, none expected", name, cyc, got);
          end else begin
            ep = exp_pix_q.pop_front();
            if (got !== ep) begin
              bad++;
              $display("FAIL %s pixel: cyc %0d got %h want %h", name, cyc, got, ep);
            end
          end
          if (got[16]) eof_cyc = cyc;
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_word  = got;
        @(negedge clk);
      end
    end
    start = 1'b0;

    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s timeout: no frame_done within 200 cycles", name);
    end else begin
      if (npix !== h * FBW || exp_addr_q.size() != 0 || exp_pix_q.size() != 0) begin
        bad++;
        $display("FAIL %s frame_len: got %0d pixels (%0d addr / %0d pix left) want %0d",
                 name, npix, exp_addr_q.size(), exp_pix_q.size(), h * FBW);
      end
      total++;
      if (done_cyc !== eof_cyc + 1) begin
        bad++;
        $display("FAIL %s done_latency: done cyc %0d want %0d", name, done_cyc, eof_cyc + 1);
      end
      if (mode != 1) begin
        total++;
        if (first_rd !== 1 || first_val !== 2) begin
          bad++;
          $display("FAIL %s first_latency: read %0d valid %0d want 1 2", name, first_rd, first_val);
        end
      end
      if (mode == 0) begin
        total++;
        if (last_rd !== h * FBW || done_cyc !== h * FBW + 2) begin
          bad++;
          $display("FAIL %s throughput: last read %0d done %0d want %0d %0d",
                   name, last_rd, done_cyc, h * FBW, h * FBW + 2);
        end
      end
      if (mode == 2) begin
        total++;
        if (stall_reads > 2) begin
          bad++;
          $display("FAIL %s stall_reads: got %0d want <= 2", name, stall_reads);
        end
      end
      @(negedge clk);
      #1;
      total++;
      if ({frame_done, busy} !== 2'b00) begin
        bad++;
        $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", name, frame_done, busy);
      end
    end
    exp_addr_q.delete();
    exp_pix_q.delete();
    height = '0;
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if ({bus.sram_rd_en, bus.sram_addr, bus.pix_valid, bus.pix_color, bus.pix_sol,
         bus.pix_eof, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL %s reset_values: rd_en=%b addr=%0d valid=%b color=%h sol=%b eof=%b busy=%b done=%b want all 0",
               name, bus.sram_rd_en, bus.sram_addr, bus.pix_valid, bus.pix_color,
               bus.pix_sol, bus.pix_eof, busy, frame_done);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    scan_frame("basic", 2, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    scan_frame("toggle_ready", 2, 1, 0, 0);
  endtask

  task automatic test_stall();
    scan_frame("stall10", 2, 2, 10, 0);
  endtask

  task automatic test_single_row();
    scan_frame("one_row", 1, 0, 0, 0);
  endtask

  task automatic test_zero_height();
    bus.pix_ready = 1'b1;
    height = 9'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    total++;
    if ({frame_done, busy, bus.sram_rd_en} !== 3'b100) begin
      bad++;
      $display("FAIL zero_height done: got done=%b busy=%b rd_en=%b want 1 0 0",
               frame_done, busy, bus.sram_rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({frame_done, busy, bus.sram_rd_en, bus.pix_valid} !== 4'b0000) begin
        bad++;
        $display("FAIL zero_height quiet: cyc %0d got done=%b busy=%b rd_en=%b valid=%b want 0",
                 i + 2, frame_done, busy, bus.sram_rd_en, bus.pix_valid);
      end
    end
  endtask

  task automatic test_double_start();
    scan_frame("double_start", 2, 0, 0, 4);
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] got;
    logic [17:0] ep;
    int idx;
    bit hit;
    logic [AW-1:0] a;

    a = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < FBW; c++) begin
        exp_pix_q.push_back({c == 0, (r == 1) && (c == FBW - 1), color_of(a)});
        a = a + 1'b1;
      end
    end
    idx = 0;
    hit = 1'b0;
    bus.pix_ready = 1'b1;
    height = 9'd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 20 && !hit; cyc++) begin
      #1;
      got = {bus.pix_sol, bus.pix_eof, bus.pix_color};
      if (bus.pix_valid && idx == 3) begin
        // Pixel 3 is on the bus: pull reset before it can transfer.
        n_rst = 1'b0;
        hit = 1'b1;
      end else begin
        if (bus.pix_valid) begin
          ep = exp_pix_q.pop_front();
          total++;
          if (got !== ep) begin
            bad++;
            $display("FAIL mid_reset pixel%0d: got %h want %h", idx, got, ep);
          end
          idx++;
        end
        @(negedge clk);
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reset reach_pixel3: got %0d pixels want 3 before reset", idx);
    end
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    #1;
    check_reset_values("mid_reset_hold");
    n_rst = 1'b1;
    exp_pix_q.delete();
    @(negedge clk);
    #1;
    check_reset_values("after_release");
    scan_frame("restart", 2, 0, 0, 0);
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_single_row();
    test_zero_height();
    test_double_start();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
